// File: rtl/riscv_pkg.sv
// Shared definitions for the memory arbiter: arbiter FSM states, fetch access size and width defaults.
package riscv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned PERF_CNT_W   = 32;

  // Instruction fetches are always full-word reads.
  localparam logic [2:0] FETCH_FUNCT3 = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_perf_cnt.sv
// Arbiter performance counters: pipeline stall cycles and completed bus transfers, both wrapping.
module arb_perf_cnt
  import riscv_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_i,
  input  logic                  done_i,
  output logic [PERF_CNT_W-1:0] stall_cycles_o,
  output logic [PERF_CNT_W-1:0] xfer_count_o
);

  logic [PERF_CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [PERF_CNT_W-1:0] xfer_count_q, xfer_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q + PERF_CNT_W'(stall_i);
    xfer_count_d   = xfer_count_q + PERF_CNT_W'(done_i);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cycles_q <= '0;
      xfer_count_q   <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      xfer_count_q   <= xfer_count_d;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign xfer_count_o   = xfer_count_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter onto a single memory port, data has fixed priority.
// Define MEM_ARB_PERF_CNT_EN to add the stall_cycles / xfer_count performance counters.
module mem_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_done,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [XLEN-1:0] dm_addr,
  input  logic [XLEN-1:0] dm_wdata,
  input  logic [2:0]      dm_funct3,
  output logic [XLEN-1:0] dm_rdata,
  output logic            dm_done,
  output logic            stall_f,
  output logic            stall_m,
  output logic            bus_valid,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [2:0]      bus_funct3,
  input  logic            bus_ready,
  input  logic [XLEN-1:0] bus_rdata
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] stall_cycles,
  output logic [PERF_CNT_W-1:0] xfer_count
`endif
);

  arb_state_e      state_q, state_d;
  logic            bus_valid_q, bus_valid_d;
  logic            bus_we_q, bus_we_d;
  logic [XLEN-1:0] bus_addr_q, bus_addr_d;
  logic [XLEN-1:0] bus_wdata_q, bus_wdata_d;
  logic [2:0]      bus_funct3_q, bus_funct3_d;

  // Bus fields are latched once at grant and held until the transfer completes.
  always_comb begin
    state_d      = state_q;
    bus_valid_d  = bus_valid_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_funct3_d = bus_funct3_q;
    unique case (state_q)
      IDLE: begin
        if (dm_req) begin
          state_d      = DATA;
          bus_valid_d  = 1'b1;
          bus_we_d     = dm_we;
          bus_addr_d   = dm_addr;
          bus_wdata_d  = dm_wdata;
          bus_funct3_d = dm_funct3;
        end else if (if_req) begin
          state_d      = FETCH;
          bus_valid_d  = 1'b1;
          bus_we_d     = 1'b0;
          bus_addr_d   = if_addr;
          bus_wdata_d  = '0;
          bus_funct3_d = FETCH_FUNCT3;
        end
      end
      FETCH, DATA: begin
        if (bus_ready) begin
          state_d     = IDLE;
          bus_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        bus_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      bus_valid_q  <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_funct3_q <= 3'b000;
    end else begin
      state_q      <= state_d;
      bus_valid_q  <= bus_valid_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_funct3_q <= bus_funct3_d;
    end
  end

  // Completion follows the granted owner, so a dropped request still gets its pulse.
  assign if_done  = (state_q == FETCH) && bus_ready;
  assign dm_done  = (state_q == DATA) && bus_ready;
  assign if_rdata = if_done ? bus_rdata : '0;
  assign dm_rdata = dm_done ? bus_rdata : '0;
  assign stall_f  = if_req & ~if_done;
  assign stall_m  = dm_req & ~dm_done;

  assign bus_valid  = bus_valid_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign bus_funct3 = bus_funct3_q;

`ifdef MEM_ARB_PERF_CNT_EN
  arb_perf_cnt u_perf_cnt (
    .clk            (clk),
    .reset          (reset),
    .stall_i        (stall_f | stall_m),
    .done_i         (if_done | dm_done),
    .stall_cycles_o (stall_cycles),
    .xfer_count_o   (xfer_count)
  );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scoreboard of expected bus transfers plus per-scenario cycle checks.
module tb_mem_arbiter;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic [XLEN-1:0] if_rdata;
  logic            if_done;
  logic            dm_req, dm_we;
  logic [XLEN-1:0] dm_addr, dm_wdata;
  logic [2:0]      dm_funct3;
  logic [XLEN-1:0] dm_rdata;
  logic            dm_done;
  logic            stall_f, stall_m;
  logic            bus_valid, bus_we;
  logic [XLEN-1:0] bus_addr, bus_wdata;
  logic [2:0]      bus_funct3;
  logic            bus_ready;
  logic [XLEN-1:0] bus_rdata;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0]     stall_cycles, xfer_count;
`endif

  always #5 clk = ~clk;

  mem_arbiter #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_done    (if_done),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_funct3  (dm_funct3),
    .dm_rdata   (dm_rdata),
    .dm_done    (dm_done),
    .stall_f    (stall_f),
    .stall_m    (stall_m),
    .bus_valid  (bus_valid),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_funct3 (bus_funct3),
    .bus_ready  (bus_ready),
    .bus_rdata  (bus_rdata)
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .xfer_count   (xfer_count)
`endif
  );

  typedef struct {
    logic        is_data;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    bit          hit;
    bit          both;
    logic        is_data;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] rdata;
    int          cycles;
    int          sf_low;
  } obs_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Observes (does not judge) the next done pulse within a cycle budget.
  task automatic wait_done(input int max_cyc, output obs_t o);
    o = '{default: 0};
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk); #1;
      o.cycles = i + 1;
      if (if_done && dm_done) o.both = 1'b1;
      if (!if_done && !stall_f) o.sf_low++;
      if (if_done || dm_done) begin
        o.hit     = 1'b1;
        o.is_data = dm_done;
        o.we      = bus_we;
        o.addr    = bus_addr;
        o.wdata   = bus_wdata;
        o.f3      = bus_funct3;
        o.rdata   = dm_done ? dm_rdata : if_rdata;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", bus_valid); end
    checks++; if ({bus_we, bus_addr, bus_wdata, bus_funct3} !== 68'h0) begin
      errors++; $display("FAIL reset_bus: got we=%b addr=%h wdata=%h f3=%b exp all 0", bus_we, bus_addr, bus_wdata, bus_funct3); end
    checks++; if ({if_done, dm_done, stall_f, stall_m} !== 4'b0) begin
      errors++; $display("FAIL reset_flags: got %b exp 0000", {if_done, dm_done, stall_f, stall_m}); end
`ifdef MEM_ARB_PERF_CNT_EN
    checks++; if ({stall_cycles, xfer_count} !== 64'h0) begin
      errors++; $display("FAIL reset_cnt: got %h/%h exp 0/0", stall_cycles, xfer_count); end
`endif
    reset = 1'b1;
  endtask

  task automatic test_fetch();
    exp_t e;
    @(negedge clk);
    bus_ready = 1'b1; bus_rdata = 32'h0050_0093; if_addr = 32'h100; if_req = 1'b1;
    sb.push_back('{1'b0, 1'b0, 32'h100, 32'h0, 3'b010, 32'h0050_0093});
    #1;
    checks++; if ({bus_valid, stall_f, if_done} !== 3'b010) begin
      errors++; $display("FAIL fetch_t: got valid/stall_f/done=%b exp 010", {bus_valid, stall_f, if_done}); end
    @(negedge clk); #1;
    checks++; if ({bus_valid, if_done, stall_f, dm_done} !== 4'b1100) begin
      errors++; $display("FAIL fetch_t1: got valid/done/stall_f/dm_done=%b exp 1100", {bus_valid, if_done, stall_f, dm_done}); end
    e = sb.pop_front();
    checks++; if ({bus_we, bus_addr, bus_wdata, bus_funct3, if_rdata} !== {e.we, e.addr, e.wdata, e.f3, e.rdata}) begin
      errors++; $display("FAIL fetch_data: got addr=%h f3=%b rdata=%h exp addr=%h f3=%b rdata=%h",
                         bus_addr, bus_funct3, if_rdata, e.addr, e.f3, e.rdata); end
    checks++; if (dm_rdata !== 32'h0) begin errors++; $display("FAIL fetch_dm_rdata: got %h exp 0", dm_rdata); end
    if_req = 1'b0;
    @(negedge clk); #1;
    checks++; if ({bus_valid, if_done, if_rdata} !== 34'h0) begin
      errors++; $display("FAIL fetch_after: got valid=%b done=%b rdata=%h exp 0", bus_valid, if_done, if_rdata); end
  endtask

  task automatic test_priority();
    obs_t o;
    exp_t e;
    @(negedge clk);
    bus_ready = 1'b1; bus_rdata = 32'h0;
    if_addr = 32'h104; if_req = 1'b1;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'hDEAD_BEEF; dm_funct3 = 3'b010;
    sb.push_back('{1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 3'b010, 32'h0});
    sb.push_back('{1'b0, 1'b0, 32'h104, 32'h0, 3'b010, 32'h0000_0013});
    #1;
    checks++; if ({stall_f, stall_m} !== 2'b11) begin errors++; $display("FAIL prio_stall_t: got %b exp 11", {stall_f, stall_m}); end
    for (int t = 0; t < 2; t++) begin
      wait_done(6, o);
      dm_req = 1'b0; bus_rdata = 32'h0000_0013;
      if (t == 1) if_req = 1'b0;
      checks++;
      if (!o.hit || sb.size() == 0) begin
        errors++; $display("FAIL prio_xfer%0d: no done within budget (hit=%0d queued=%0d)", t, o.hit, sb.size());
      end else begin
        e = sb.pop_front();
        if ({o.is_data, o.we, o.addr, o.wdata, o.f3, o.rdata} !== {e.is_data, e.we, e.addr, e.wdata, e.f3, e.rdata}) begin
          errors++; $display("FAIL prio_xfer%0d: got data=%b we=%b addr=%h wdata=%h rdata=%h exp data=%b we=%b addr=%h wdata=%h rdata=%h",
                             t, o.is_data, o.we, o.addr, o.wdata, o.rdata, e.is_data, e.we, e.addr, e.wdata, e.rdata);
        end
      end
      checks++; if (o.sf_low != 0) begin errors++; $display("FAIL prio_stall_f%0d: got %0d low cycles exp 0", t, o.sf_low); end
      checks++; if (o.cycles != t + 1) begin errors++; $display("FAIL prio_lat%0d: got %0d exp %0d", t, o.cycles, t + 1); end
    end
  endtask

  task automatic test_wait_states();
    exp_t e;
    @(negedge clk);
    bus_ready = 1'b0; bus_rdata = 32'hBAD0_BAD0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2004; dm_wdata = 32'h0; dm_funct3 = 3'b010;
    sb.push_back('{1'b1, 1'b0, 32'h2004, 32'h0, 3'b010, 32'h1234_5678});
    e = sb[0];
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 4) begin bus_ready = 1'b1; bus_rdata = 32'h1234_5678; end
      #1;
      checks++; if ({bus_valid, bus_we, bus_addr, bus_wdata, bus_funct3} !== {1'b1, e.we, e.addr, e.wdata, e.f3}) begin
        errors++; $display("FAIL ws_bus%0d: got valid=%b we=%b addr=%h f3=%b exp 1/%b/%h/%b",
                           k, bus_valid, bus_we, bus_addr, bus_funct3, e.we, e.addr, e.f3); end
      checks++; if ({dm_done, stall_m} !== {(k == 4), (k != 4)}) begin
        errors++; $display("FAIL ws_done%0d: got done/stall_m=%b%b exp %b%b", k, dm_done, stall_m, (k == 4), (k != 4)); end
      checks++; if (dm_rdata !== ((k == 4) ? e.rdata : 32'h0)) begin
        errors++; $display("FAIL ws_rdata%0d: got %h exp %h", k, dm_rdata, (k == 4) ? e.rdata : 32'h0); end
    end
    void'(sb.pop_front());
    dm_req = 1'b0;
  endtask

  task automatic test_mid_reset();
    obs_t o;
    exp_t e;
    @(negedge clk);
    bus_ready = 1'b0;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h3000; dm_wdata = 32'hCAFE_F00D; dm_funct3 = 3'b001;
    @(negedge clk); #1;
    checks++; if (bus_valid !== 1'b1) begin errors++; $display("FAIL mrst_active: got %b exp 1", bus_valid); end
    reset = 1'b0; dm_req = 1'b0;
    @(negedge clk); #1;
    checks++; if ({bus_valid, bus_we, bus_addr, bus_wdata, bus_funct3} !== 69'h0) begin
      errors++; $display("FAIL mrst_bus: got valid=%b we=%b addr=%h wdata=%h f3=%b exp all 0",
                         bus_valid, bus_we, bus_addr, bus_wdata, bus_funct3); end
`ifdef MEM_ARB_PERF_CNT_EN
    checks++; if ({stall_cycles, xfer_count} !== 64'h0) begin
      errors++; $display("FAIL mrst_cnt: got %h/%h exp 0/0", stall_cycles, xfer_count); end
`endif
    bus_ready = 1'b1; #1;
    checks++; if (dm_done !== 1'b0) begin errors++; $display("FAIL mrst_no_done: got %b exp 0", dm_done); end
    reset = 1'b1;
    @(negedge clk);
    bus_rdata = 32'h0000_0013; if_addr = 32'h200; if_req = 1'b1;
    sb.push_back('{1'b0, 1'b0, 32'h200, 32'h0, 3'b010, 32'h0000_0013});
    wait_done(6, o);
    if_req = 1'b0;
    checks++;
    if (!o.hit || sb.size() == 0) begin
      errors++; $display("FAIL mrst_fetch: no done within budget (hit=%0d queued=%0d)", o.hit, sb.size());
    end else begin
      e = sb.pop_front();
      if ({o.is_data, o.we, o.addr, o.f3, o.rdata, o.cycles} !== {e.is_data, e.we, e.addr, e.f3, e.rdata, 32'd1}) begin
        errors++; $display("FAIL mrst_fetch: got data=%b addr=%h rdata=%h lat=%0d exp data=%b addr=%h rdata=%h lat=1",
                           o.is_data, o.addr, o.rdata, o.cycles, e.is_data, e.addr, e.rdata);
      end
    end
  endtask

  task automatic test_flush();
    exp_t e;
    int   extra;
    logic [31:0] s0, x0;
    s0 = 32'h0; x0 = 32'h0;
    @(negedge clk);
`ifdef MEM_ARB_PERF_CNT_EN
    s0 = stall_cycles; x0 = xfer_count;
`endif
    bus_ready = 1'b0; bus_rdata = 32'hBAD0_BAD0; if_addr = 32'h300; if_req = 1'b1;
    sb.push_back('{1'b0, 1'b0, 32'h300, 32'h0, 3'b010, 32'h1111_1111});
    #1;
    checks++; if (stall_f !== 1'b1) begin errors++; $display("FAIL flush_stall_t: got %b exp 1", stall_f); end
    @(negedge clk);
    if_req = 1'b0;
    #1;
    checks++; if ({bus_valid, if_done, stall_f} !== 3'b100) begin
      errors++; $display("FAIL flush_dropped: got valid/done/stall_f=%b exp 100", {bus_valid, if_done, stall_f}); end
    @(negedge clk);
    bus_ready = 1'b1; bus_rdata = 32'h1111_1111;
    #1;
    e = sb.pop_front();
    checks++; if ({if_done, bus_addr, if_rdata} !== {1'b1, e.addr, e.rdata}) begin
      errors++; $display("FAIL flush_done: got done=%b addr=%h rdata=%h exp 1/%h/%h", if_done, bus_addr, if_rdata, e.addr, e.rdata); end
    extra = 0;
    repeat (3) begin
      @(negedge clk); #1;
      if (if_done || dm_done) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL flush_extra_pulse: got %0d exp 0", extra); end
`ifdef MEM_ARB_PERF_CNT_EN
    checks++; if (xfer_count - x0 !== 32'd1) begin errors++; $display("FAIL flush_xfer_cnt: got +%0d exp +1", xfer_count - x0); end
    checks++; if (stall_cycles - s0 !== 32'd1) begin errors++; $display("FAIL flush_stall_cnt: got +%0d exp +1", stall_cycles - s0); end
`endif
  endtask

  task automatic test_back_to_back();
    obs_t o;
    exp_t e;
    logic [31:0] a, rd, wd;
    logic        w;
    logic [2:0]  f3;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a = $urandom & 32'hFFFF_FFFC; rd = $urandom; wd = $urandom;
      w = 1'($urandom_range(0, 1)); f3 = 3'($urandom_range(0, 7));
      bus_ready = 1'b1; bus_rdata = rd;
      if ($urandom_range(0, 1) == 1) begin
        dm_req = 1'b1; dm_we = w; dm_addr = a; dm_wdata = wd; dm_funct3 = f3;
        if_addr = ~a;
        sb.push_back('{1'b1, w, a, wd, f3, rd});
      end else begin
        if_req = 1'b1; if_addr = a;
        dm_addr = ~a; dm_wdata = wd; dm_funct3 = f3; dm_we = w;
        sb.push_back('{1'b0, 1'b0, a, 32'h0, 3'b010, rd});
      end
      wait_done(4, o);
      if_req = 1'b0; dm_req = 1'b0;
      checks++;
      if (!o.hit || sb.size() == 0) begin
        errors++; $display("FAIL b2b%0d: no done within budget (hit=%0d queued=%0d)", i, o.hit, sb.size());
      end else begin
        e = sb.pop_front();
        if ({o.is_data, o.we, o.addr, o.wdata, o.f3, o.rdata, o.both, o.cycles} !==
            {e.is_data, e.we, e.addr, e.wdata, e.f3, e.rdata, 1'b0, 32'd1}) begin
          errors++; $display("FAIL b2b%0d: got data=%b we=%b addr=%h wdata=%h f3=%b rdata=%h both=%b lat=%0d exp data=%b we=%b addr=%h wdata=%h f3=%b rdata=%h both=0 lat=1",
                             i, o.is_data, o.we, o.addr, o.wdata, o.f3, o.rdata, o.both, o.cycles,
                             e.is_data, e.we, e.addr, e.wdata, e.f3, e.rdata);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0; if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_funct3 = 3'b000;
    bus_ready = 1'b0; bus_rdata = '0;
    test_reset();
    test_fetch();
    test_priority();
    test_wait_states();
    test_mid_reset();
    test_flush();
    test_back_to_back();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d entries exp 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
